// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer. The channel is locked at packet start,
// each channel has a one-entry output register, and beats sent to a nonexistent channel are dropped and counted.
module demux_1xn_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  output logic [N-1:0]       out_valid,
  output logic [N*WIDTH-1:0] out_data,
  input  logic [N-1:0]       out_ready,
  output logic               busy,
  output logic [SEL_W-1:0]   cur_sel,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned SELX_W = SEL_W + 1;
  localparam logic [SELX_W-1:0] N_X = SELX_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [N-1:0]        out_valid_q, out_valid_d;
  logic [N*WIDTH-1:0]  out_data_q, out_data_d;

  logic [SEL_W-1:0]    tgt;
  logic                sel_legal;
  logic                drop_mode;
  logic                accept;
  logic [N-1:0]        tgt_hit;
  logic [N-1:0]        wr;

  // Target decode and handshake; one-hot compare avoids indexing past N.
  always_comb begin
    tgt       = (state_q == IDLE) ? in_sel : cur_sel_q;
    sel_legal = {1'b0, in_sel} < N_X;
    drop_mode = (state_q == DROP) || ((state_q == IDLE) && !sel_legal);
    for (int unsigned k = 0; k < N; k++) begin
      tgt_hit[k] = (tgt == SEL_W'(k));
    end
    in_ready = drop_mode || (|(tgt_hit & (~out_valid_q | out_ready)));
    accept   = in_valid && in_ready;
    wr       = (accept && !drop_mode) ? tgt_hit : '0;
  end

  // Next state: channel registers drain and reload in the same cycle without a bubble.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    drop_cnt_d  = drop_cnt_q;
    out_valid_d = (out_valid_q & ~out_ready) | wr;
    out_data_d  = out_data_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (wr[k]) begin
        out_data_d[k*WIDTH +: WIDTH] = in_data;
      end
    end
    if (accept && drop_mode && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            if (sel_legal) begin
              state_d   = FWD;
              cur_sel_d = in_sel;
            end else begin
              state_d = DROP;
            end
          end
        end
        FWD: begin
          if (in_last) begin
            state_d   = IDLE;
            cur_sel_d = '0;
          end
        end
        DROP: begin
          if (in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_sel_q   <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign cur_sel   = cur_sel_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed bench for demux_1xn_stream: N=4 routing/lock/backpressure/reset, N=3 drop and saturation.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // N=4 instance
  logic        rst_a, a_iv, a_ir, a_il, a_busy;
  logic [7:0]  a_id, a_drop;
  logic [1:0]  a_is, a_cur;
  logic [3:0]  a_ov, a_or;
  logic [31:0] a_od;

  // Two N=3 instances on shared stimulus, wide and 2-bit drop counters
  logic        rst_b, b_iv, b_il, b_ir, c_ir, b_busy, c_busy;
  logic [7:0]  b_id, b_drop;
  logic [1:0]  b_is, b_cur, c_cur, c_drop;
  logic [2:0]  b_or, b_ov, c_ov;
  logic [23:0] b_od, c_od;

  demux_1xn_stream #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_sel(a_is),
    .in_last(a_il), .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .busy(a_busy),
    .cur_sel(a_cur), .drop_cnt(a_drop));

  demux_1xn_stream #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_sel(b_is),
    .in_last(b_il), .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .busy(b_busy),
    .cur_sel(b_cur), .drop_cnt(b_drop));

  demux_1xn_stream #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst_b), .in_valid(b_iv), .in_ready(c_ir), .in_data(b_id), .in_sel(b_is),
    .in_last(b_il), .out_valid(c_ov), .out_data(c_od), .out_ready(b_or), .busy(c_busy),
    .cur_sel(c_cur), .drop_cnt(c_drop));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic       last;
    logic [3:0] rdy;
    logic       e_ird;
    logic [3:0] e_ov;
    logic       e_busy;
    logic [1:0] e_cur;
    logic [1:0] e_ch;
    logic [7:0] e_d;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  // Drive one beat into the N=3 pair; in_ready is expected high for every beat used here.
  task automatic b_beat(input logic [1:0] sel, input logic [7:0] d, input logic last, input string nm);
    b_iv = 1'b1; b_is = sel; b_id = d; b_il = last;
    #1;
    chk({nm, " b_in_ready"}, 32'(b_ir), 32'd1);
    chk({nm, " c_in_ready"}, 32'(c_ir), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    // v sel d last rdy | in_ready ov busy cur ch data
    tbl[0]  = '{1'b1, 2'd0, 8'hA0, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 8'hA0};
    tbl[1]  = '{1'b1, 2'd1, 8'hA1, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd1, 8'hA1};
    tbl[2]  = '{1'b1, 2'd2, 8'hA2, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd0, 2'd2, 8'hA2};
    tbl[3]  = '{1'b1, 2'd3, 8'hA3, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b0, 2'd0, 2'd3, 8'hA3};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd3, 8'hA3};
    tbl[5]  = '{1'b1, 2'd2, 8'h11, 1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 8'h11};
    tbl[6]  = '{1'b1, 2'd1, 8'h22, 1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 8'h22};
    tbl[7]  = '{1'b1, 2'd1, 8'h33, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd0, 2'd2, 8'h33};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd2, 8'h33};
    tbl[9]  = '{1'b1, 2'd1, 8'h44, 1'b0, 4'hD, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1, 8'h44};
    tbl[10] = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hD, 1'b0, 4'b0010, 1'b1, 2'd1, 2'd1, 8'h44};
    tbl[11] = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hD, 1'b0, 4'b0010, 1'b1, 2'd1, 2'd1, 8'h44};
    tbl[12] = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd1, 8'h55};
    tbl[13] = '{1'b1, 2'd3, 8'h66, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b0, 2'd0, 2'd3, 8'h66};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd3, 8'h66};

    rst_a = 1'b1; a_iv = 1'b0; a_id = '0; a_is = '0; a_il = 1'b0; a_or = 4'hF;
    rst_b = 1'b1; b_iv = 1'b0; b_id = '0; b_is = '0; b_il = 1'b0; b_or = 3'b111;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(a_ov), 32'd0);
    chk("rst out_data", a_od, 32'd0);
    chk("rst busy", 32'(a_busy), 32'd0);
    chk("rst cur_sel", 32'(a_cur), 32'd0);
    chk("rst drop_cnt", 32'(a_drop), 32'd0);

    // Routing, packet lock and backpressure on the N=4 instance
    for (int i = 0; i < NV; i++) begin
      a_iv = tbl[i].v; a_is = tbl[i].sel; a_id = tbl[i].d; a_il = tbl[i].last; a_or = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(a_ir), 32'(tbl[i].e_ird));
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), 32'(a_ov), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d busy", i), 32'(a_busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d cur_sel", i), 32'(a_cur), 32'(tbl[i].e_cur));
      chk($sformatf("v%0d out_data", i), 32'(a_od[int'(tbl[i].e_ch)*8 +: 8]), 32'(tbl[i].e_d));
      chk($sformatf("v%0d drop_cnt", i), 32'(a_drop), 32'd0);
    end
    a_iv = 1'b0;

    // Illegal select on N=3: 4-beat packet to sel=3, in_sel wiggled mid-packet
    for (int i = 0; i < 4; i++) begin
      b_beat((i == 1 || i == 2) ? 2'd0 : 2'd3, 8'(8'h90 + i), (i == 3), $sformatf("drop%0d", i));
      chk($sformatf("drop%0d b_out_valid", i), 32'(b_ov), 32'd0);
      chk($sformatf("drop%0d c_out_valid", i), 32'(c_ov), 32'd0);
      chk($sformatf("drop%0d b_drop_cnt", i), 32'(b_drop), 32'(i + 1));
      chk($sformatf("drop%0d c_drop_cnt", i), 32'(c_drop), 32'((i < 2) ? i + 1 : 3));
      chk($sformatf("drop%0d busy", i), 32'(b_busy), 32'(i < 3));
    end
    b_beat(2'd0, 8'h55, 1'b1, "legal_after_drop");
    chk("legal_after_drop out_valid", 32'(b_ov), 32'b001);
    chk("legal_after_drop out_data", 32'(b_od[7:0]), 32'h55);
    chk("legal_after_drop drop_cnt", 32'(b_drop), 32'd4);
    b_iv = 1'b0;
    @(negedge clk);
    chk("legal_after_drop drained", 32'(b_ov), 32'd0);

    // Saturation of the 2-bit drop counter
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("sat rst c_drop_cnt", 32'(c_drop), 32'd0);
    for (int i = 0; i < 6; i++) begin
      b_beat(2'd3, 8'(i), 1'b1, $sformatf("sat%0d", i));
      chk($sformatf("sat%0d c_drop_cnt", i), 32'(c_drop), 32'((i < 3) ? i + 1 : 3));
      chk($sformatf("sat%0d b_drop_cnt", i), 32'(b_drop), 32'(i + 1));
      chk($sformatf("sat%0d busy", i), 32'(c_busy), 32'd0);
      chk($sformatf("sat%0d out_valid", i), 32'(c_ov), 32'd0);
    end
    b_iv = 1'b0;

    // Asynchronous reset in the middle of a sel=1 packet on the N=4 instance
    a_iv = 1'b1; a_is = 2'd1; a_id = 8'h71; a_il = 1'b0; a_or = 4'hD;
    @(negedge clk);
    chk("arst pre out_valid", 32'(a_ov), 32'b0010);
    chk("arst pre busy", 32'(a_busy), 32'd1);
    chk("arst pre cur_sel", 32'(a_cur), 32'd1);
    a_id = 8'h72;
    #2 rst_a = 1'b1;
    #1;
    chk("arst out_valid", 32'(a_ov), 32'd0);
    chk("arst busy", 32'(a_busy), 32'd0);
    chk("arst cur_sel", 32'(a_cur), 32'd0);
    chk("arst out_data", a_od, 32'd0);
    @(negedge clk);
    rst_a = 1'b0; a_iv = 1'b0; a_or = 4'hF;
    @(negedge clk);
    a_iv = 1'b1; a_is = 2'd1; a_id = 8'h81; a_il = 1'b1;
    @(negedge clk);
    chk("post_rst out_valid", 32'(a_ov), 32'b0010);
    chk("post_rst out_data", 32'(a_od[15:8]), 32'h81);
    chk("post_rst busy", 32'(a_busy), 32'd0);
    a_iv = 1'b0;
    @(negedge clk);
    chk("post_rst drained", 32'(a_ov), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1xn_stream.md
Name: demux_1xn_stream

Overview:
Parametrised, registered 1-to-N stream demultiplexer: the next generation of the combinational 1x4 demux. Routes valid/ready beats from one input stream to one of N output channels. The channel is selected at packet start and locked until the last beat. Each channel has a one-entry output register, which decouples per-channel backpressure. Beats addressed to a nonexistent channel are dropped and counted. Sits between a shared source (e.g. a UART/packet parser) and per-consumer pipelines.

Parameters:
WIDTH, 8, data bits per beat
N, 4, number of output channels (2..16; need not be a power of two)
SEL_W, 2, select width; must satisfy 2**SEL_W >= N
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  WIDTH  input beat payload
in_sel  in  SEL_W  destination channel; sampled only on a packet's first beat
in_last  in  1  marks the final beat of a packet
out_valid  out  N  per-channel valid; bit k is channel k
out_data  out  N*WIDTH  per-channel payload; channel k occupies bits [k*WIDTH +: WIDTH]
out_ready  in  N  per-channel ready
busy  out  1  high while a packet is mid-flight (state != IDLE)
cur_sel  out  SEL_W  locked channel; 0 when IDLE
drop_cnt  out  CNT_W  count of dropped beats, saturating

Behaviour:
- Reset (async, rst=1):
  - out_valid=0 and out_data=0 on all channels.
  - State=IDLE, cur_sel=0, drop_cnt=0, busy=0.
  - Any buffered or in-flight beats are discarded. Reset mid-packet leaves no residue.
- States: IDLE, FWD, DROP.
- Target channel: tgt = in_sel in IDLE; tgt = cur_sel in FWD.
- Legality: a select is illegal if in_sel >= N.
- in_ready is combinational:
  - IDLE with illegal in_sel: in_ready=1.
  - DROP: in_ready=1.
  - Otherwise: in_ready = !out_valid[tgt] || out_ready[tgt].
- Accept (in_valid && in_ready) to a legal target:
  - out_data[tgt] <= in_data and out_valid[tgt] <= 1 at the next edge.
  - Latency is 1 cycle from accept to out_valid.
  - Other channels are untouched.
- Drain: a channel with out_valid=1 and out_ready=1 and no new write that cycle clears out_valid at the next edge. out_data holds its last value.
- Simultaneous drain and write on the same channel: the register reloads, out_valid stays 1, and there is no bubble. Full throughput is 1 beat/cycle per packet.
- Channel independence: a stalled channel (out_ready=0) blocks only packets routed to it. Other channels keep draining.
- Transitions:
  - IDLE, accept, legal, !in_last: FWD, and cur_sel <= in_sel.
  - IDLE, accept, legal, in_last: stay IDLE (single-beat packet).
  - IDLE, accept, illegal, !in_last: DROP.
  - IDLE, accept, illegal, in_last: stay IDLE.
  - FWD, accept, in_last: IDLE, cur_sel <= 0.
  - DROP, accept, in_last: IDLE.
  - No accept: hold state.
- in_sel is ignored in FWD and DROP. A mid-packet change of in_sel must not reroute the packet.
- Every beat accepted in DROP, or in IDLE with an illegal select, increments drop_cnt. drop_cnt saturates at 2**CNT_W-1 with no wrap. Dropped beats never set any out_valid.
- in_valid=0: no state change. in_data, in_sel and in_last are don't-care.
- Handshake rules:
  - Outputs are standard valid/ready. Once out_valid[k]=1, out_data[k] is stable until the beat is taken.
  - The source must hold in_data, in_sel and in_last while in_valid && !in_ready.
- Power-of-two N (N=4, SEL_W=2): no select is illegal, so the DROP state is unreachable.

Test Plan:
- Reset and route: N=4. After rst, check all outputs are 0. Send single-beat packets sel=0..3, data=8'hA0+sel, all out_ready=1. Each out_valid[sel] pulses exactly 1 cycle after accept with the matching data. drop_cnt=0.
- Packet lock: sel=2, 3 beats (11,22,33), in_sel toggled to 1 on beats 2-3. All three beats appear on channel 2 only. busy=1 from after beat 1 until after beat 3. cur_sel=2 then 0.
- Backpressure isolation: out_ready[1]=0. Send 2 beats to ch1. The first is buffered. The second sees in_ready=0 and is held. A concurrent next packet to ch3 is not accepted until the ch1 packet ends. Release out_ready[1]: the second beat is accepted and the back-to-back drain/write shows no bubble.
- Illegal select: N=3, SEL_W=2. Send a 4-beat packet with sel=3. in_ready=1 throughout. No out_valid rises. drop_cnt goes 0 to 4 and the state returns to IDLE. Then sel=0 data 8'h55 appears on ch0.
- Saturation: CNT_W=2. Drop 6 single-beat packets. drop_cnt reaches 3 and holds at 3.
- Async reset mid-packet: assert rst (between clock edges) during beat 2 of a sel=1 packet. Without waiting for a clock edge, out_valid=0, busy=0 and cur_sel=0. A fresh packet to ch1 after release routes normally.
